// File: rtl/key_expand_ctrl.sv
// AES-128 key-expansion sequencer: drives an external multi-cycle G unit once per
// round, performs the four-word XOR chain and hands out round keys 0..NUM_ROUNDS.
module key_expand_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned G_TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         g_enable,
    output logic [31:0]  g_input,
    output logic [3:0]   g_round,
    input  logic [31:0]  g_output,
    input  logic         g_done,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_num,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RND_W  = 4;
    localparam int unsigned TMO_W  = $clog2(G_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_REQ,
        S_WAIT,
        S_MIX
    } state_t;

    state_t              state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [RND_W-1:0]    round_q, round_d;
    logic [WORD_W-1:0]   t_q, t_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                g_enable_d;
    logic [WORD_W-1:0]   g_input_d;
    logic [RND_W-1:0]    g_round_d;
    logic                rk_valid_d;
    logic                busy_d;
    logic                done_d;
    logic                err_d;

    // XOR chain: each new word folds in the freshly produced word before it
    logic [WORD_W-1:0] mix_w0, mix_w1, mix_w2, mix_w3;
    assign mix_w0 = key_q[127:96] ^ t_q;
    assign mix_w1 = key_q[95:64]  ^ mix_w0;
    assign mix_w2 = key_q[63:32]  ^ mix_w1;
    assign mix_w3 = key_q[31:0]   ^ mix_w2;

    // The key and round registers are the round-key outputs themselves
    assign rk_data = key_q;
    assign rk_num  = round_q;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        round_d    = round_q;
        t_d        = t_q;
        tmo_d      = tmo_q;
        g_enable_d = 1'b0;
        g_input_d  = g_input;
        g_round_d  = g_round;
        rk_valid_d = rk_valid;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d      = key_in;
                    round_d    = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    rk_valid_d = 1'b1;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (rk_ready) begin
                    rk_valid_d = 1'b0;
                    if (round_q == RND_W'(NUM_ROUNDS)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        g_enable_d = 1'b1;
                        g_input_d  = key_q[31:0];
                        g_round_d  = round_q + RND_W'(1);
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (g_done) begin
                    t_d     = g_output;
                    state_d = S_MIX;
                end else if (tmo_q == TMO_W'(G_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_MIX: begin
                key_d      = {mix_w0, mix_w1, mix_w2, mix_w3};
                round_d    = round_q + RND_W'(1);
                rk_valid_d = 1'b1;
                state_d    = S_EMIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            round_q  <= '0;
            t_q      <= '0;
            tmo_q    <= '0;
            g_enable <= 1'b0;
            g_input  <= '0;
            g_round  <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            round_q  <= round_d;
            t_q      <= t_d;
            tmo_q    <= tmo_d;
            g_enable <= g_enable_d;
            g_input  <= g_input_d;
            g_round  <= g_round_d;
            rk_valid <= rk_valid_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: behavioural G unit plus a word-array AES-128
// key-expansion reference model, directed scenarios mixed with random keys.
module tb_key_expand_ctrl;

    localparam int unsigned NR = 10;
    localparam int unsigned GT = 64;

    logic         tb_clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [127:0] key_in;
    logic         g_enable;
    logic [31:0]  g_input;
    logic [3:0]   g_round;
    logic [31:0]  g_output;
    logic         g_done;
    logic [127:0] rk_data;
    logic [3:0]   rk_num;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;
    logic         err;

    always #5 tb_clk = ~tb_clk;

    key_expand_ctrl #(.NUM_ROUNDS(NR), .G_TIMEOUT(GT)) dut (
        .clk(tb_clk), .n_rst(n_rst), .start(start), .key_in(key_in),
        .g_enable(g_enable), .g_input(g_input), .g_round(g_round),
        .g_output(g_output), .g_done(g_done),
        .rk_data(rk_data), .rk_num(rk_num), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .busy(busy), .done(done), .err(err)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox   [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got_rk [0:10];

    int           g_lat    = 12;
    bit           g_silent = 1'b0;
    logic [31:0]  g_log_in    [$];
    logic [3:0]   g_log_round [$];
    int           g_en_cnt = 0;
    int           done_cnt = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // G = SubWord(RotWord(w)) ^ Rcon(rnd)
    function automatic logic [31:0] g_fn(input logic [31:0] w, input logic [3:0] rnd);
        logic [31:0] r;
        logic [7:0]  rc;
        r  = {w[23:0], w[31:24]};
        r  = {sbox[r[31:24]], sbox[r[23:16]], sbox[r[15:8]], sbox[r[7:0]]};
        rc = 8'h01;
        for (int i = 1; i < int'(rnd); i++) rc = xtime(rc);
        return r ^ {rc, 24'h000000};
    endfunction

    task automatic compute_expected(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = g_fn(tmp, 4'(i / 4));
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural G unit: g_done arrives g_lat cycles after the request cycle
    initial begin : g_unit
        logic [31:0] cin;
        logic [3:0]  crnd;
        g_done   = 1'b0;
        g_output = 32'h0;
        forever begin
            @(negedge tb_clk);
            if (g_enable === 1'b1) begin
                cin  = g_input;
                crnd = g_round;
                g_log_in.push_back(cin);
                g_log_round.push_back(crnd);
                if (!g_silent) begin
                    repeat (g_lat) @(negedge tb_clk);
                    if (busy === 1'b1) check("g_input_held", 128'(g_input), 128'(cin));
                    g_done   = 1'b1;
                    g_output = g_fn(cin, crnd);
                    @(negedge tb_clk);
                    g_done   = 1'b0;
                    g_output = $urandom;
                end
            end
        end
    end

    always @(negedge tb_clk) begin
        if (g_enable === 1'b1) g_en_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input logic [127:0] k);
        compute_expected(k);
        @(negedge tb_clk);
        start  = 1'b1;
        key_in = k;
        @(negedge tb_clk);
        start  = 1'b0;
        key_in = rand_key();
        check("start_rk_valid", 128'(rk_valid), 128'(1));
        check("start_busy", 128'(busy), 128'(1));
        check("start_err_clear", 128'(err), 128'(0));
    endtask

    task automatic consume(input int last_r, input int stall_at, input int stall_len,
                           input bit rand_ready, input bit chk_lat, input bit busy_start,
                           input bit end_start, input logic [127:0] end_key);
        for (int r = 0; r <= last_r; r++) begin
            int cnt;
            int stall;
            int gsnap;
            bit stable;
            cnt = 0;
            while (rk_valid !== 1'b1 && cnt < 500) begin
                @(negedge tb_clk);
                cnt++;
            end
            check($sformatf("rk_valid_r%0d", r), 128'(rk_valid), 128'(1));
            if (rk_valid !== 1'b1) return;
            check($sformatf("rk_num_r%0d", r), 128'(rk_num), 128'(r));
            check($sformatf("rk_data_r%0d", r), rk_data, exp_rk[r]);
            got_rk[r] = rk_data;
            if (chk_lat && r > 0) check("round_latency", 128'(cnt), 128'(g_lat + 2));
            stall = (r == stall_at) ? stall_len : (rand_ready ? int'($urandom_range(0, 3)) : 0);
            if (stall > 0) begin
                rk_ready = 1'b0;
                gsnap    = g_en_cnt;
                stable   = 1'b1;
                repeat (stall) begin
                    @(negedge tb_clk);
                    if (rk_valid !== 1'b1 || rk_data !== exp_rk[r] || rk_num !== 4'(r)) stable = 1'b0;
                end
                check("stall_stable", 128'(stable), 128'(1));
                check("stall_no_g_enable", 128'(g_en_cnt - gsnap), 128'(0));
                rk_ready = 1'b1;
            end
            if (busy_start && r == 5) begin
                start  = 1'b1;
                key_in = ~exp_rk[0];
            end
            if (end_start && r == int'(NR)) begin
                start  = 1'b1;
                key_in = ~end_key;
            end
            @(negedge tb_clk);
            if (end_start && r == int'(NR)) key_in = end_key;
            else start = 1'b0;
            check("rk_valid_drop", 128'(rk_valid), 128'(0));
            if (r == int'(NR)) begin
                check("done_pulse", 128'(done), 128'(1));
                check("busy_fall", 128'(busy), 128'(0));
            end
        end
    endtask

    initial begin : main
        logic [127:0] k, k2;
        int           dsnap, gsnap, cnt;
        bit           ok;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        n_rst = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b1;
        repeat (2) @(negedge tb_clk);
        check("reset_rk_data", rk_data, 128'(0));
        check("reset_ctrl", 128'({g_enable, g_input, g_round, rk_num, rk_valid, busy, done, err}), 128'(0));
        n_rst = 1'b1;

        // FIPS-197 appendix A.1 key with fixed G latency
        g_lat = 12;
        g_log_in.delete(); g_log_round.delete();
        dsnap = done_cnt;
        do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
        consume(NR, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("fips_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_rk2", got_rk[2], 128'hf2c295f27a96b9435935807a7359f67f);
        check("fips_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_g_count", 128'(g_log_round.size()), 128'(NR));
        ok = 1'b1;
        foreach (g_log_round[i]) if (g_log_round[i] !== 4'(i + 1)) ok = 1'b0;
        check("fips_g_round_seq", 128'(ok), 128'(1));
        if (g_log_in.size() > 0) check("fips_g_input_r1", 128'(g_log_in[0]), 128'(32'h09cf4f3c));
        repeat (3) @(negedge tb_clk);
        check("fips_done_once", 128'(done_cnt - dsnap), 128'(1));
        check("fips_idle_busy", 128'(busy), 128'(0));

        // All-zero key
        g_lat = int'($urandom_range(1, 16));
        g_log_in.delete(); g_log_round.delete();
        do_start('0);
        consume(NR, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        if (g_log_in.size() > 0) begin
            check("zero_g_input", 128'(g_log_in[0]), 128'(0));
            check("zero_g_round", 128'(g_log_round[0]), 128'(1));
        end
        check("zero_rk1", got_rk[1], 128'h62636363626363636263636362636363);

        // Back-pressure for 20 cycles at round 3
        g_lat = int'($urandom_range(1, 16));
        do_start(rand_key());
        consume(NR, 3, 20, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Start while busy, start in the acceptance cycle of the last key, then one cycle later
        g_lat = int'($urandom_range(1, 16));
        k2 = rand_key();
        do_start(rand_key());
        consume(NR, -1, 0, 1'b0, 1'b0, 1'b1, 1'b1, k2);
        @(negedge tb_clk);
        start = 1'b0;
        check("late_start_valid", 128'(rk_valid), 128'(1));
        check("late_start_key", rk_data, k2);
        check("late_start_num", 128'(rk_num), 128'(0));
        check("late_start_busy", 128'(busy), 128'(1));
        compute_expected(k2);
        consume(NR, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // G never answers
        g_silent = 1'b1;
        do_start(rand_key());
        dsnap = done_cnt;
        @(negedge tb_clk);
        check("tmo_req_pulse", 128'(g_enable), 128'(1));
        cnt = 0;
        while (err !== 1'b1 && cnt < 200) begin
            @(negedge tb_clk);
            cnt++;
        end
        check("tmo_err", 128'(err), 128'(1));
        check("tmo_cycles", 128'(cnt >= int'(GT) && cnt <= int'(GT) + 2), 128'(1));
        check("tmo_busy", 128'(busy), 128'(0));
        check("tmo_rk_valid", 128'(rk_valid), 128'(0));
        repeat (2) @(negedge tb_clk);
        check("tmo_no_done", 128'(done_cnt - dsnap), 128'(0));
        check("tmo_err_sticky", 128'(err), 128'(1));
        g_silent = 1'b0;
        g_lat = int'($urandom_range(1, 16));
        do_start(rand_key());
        consume(NR, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Reset during the round-6 G wait
        g_lat = 12;
        do_start(rand_key());
        consume(5, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("rst_req_pulse", 128'(g_enable), 128'(1));
        check("rst_req_round", 128'(g_round), 128'(6));
        repeat (4) @(negedge tb_clk);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_rk_data", rk_data, 128'(0));
        check("async_rst_ctrl", 128'({g_enable, g_input, g_round, rk_num, rk_valid, busy, done, err}), 128'(0));
        gsnap = g_en_cnt;
        dsnap = done_cnt;
        @(negedge tb_clk);
        @(negedge tb_clk);
        n_rst = 1'b1;
        repeat (20) @(negedge tb_clk);
        check("post_rst_busy", 128'(busy), 128'(0));
        check("post_rst_rk_valid", 128'(rk_valid), 128'(0));
        check("post_rst_no_g_enable", 128'(g_en_cnt - gsnap), 128'(0));
        check("post_rst_no_done", 128'(done_cnt - dsnap), 128'(0));
        do_start(rand_key());
        consume(NR, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Random keys, latencies and consumer stalls
        for (int n = 0; n < 3; n++) begin
            g_lat = int'($urandom_range(1, 16));
            k = rand_key();
            do_start(k);
            consume(NR, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        end

        repeat (3) @(negedge tb_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
